fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction fetch front end. Produces the instruction stream whose opcode, funct3 and funct7 fields feed control-word decode.
- Owns the fetch PC and issues single-outstanding reads on the instruction memory port.
- Buffers returned instructions in a small FIFO and presents them to decode with a valid/ready handshake.
- Accepts a PC redirect from branch/jump resolution, which flushes all younger fetched state.

Parameters:
- DEPTH, 4, number of FIFO entries (power of two, >= 2)
- RESET_PC, 32'h00000060, fetch PC loaded on reset

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- inst_mem_read  out  1  instruction read request
- inst_mem_address  out  32  word-aligned fetch address
- inst_mem_rdata  in  32  read data, valid when inst_mem_resp=1
- inst_mem_resp  in  1  read completes this cycle
- redirect_valid  in  1  branch/jump taken; flush and refetch
- redirect_pc  in  32  redirect target; bits [1:0] ignored
- deq_valid  out  1  head instruction available
- deq_ready  in  1  decode accepts head this cycle
- deq_pc  out  32  PC of head instruction
- deq_inst  out  32  head instruction word
- deq_opcode  out  7  deq_inst[6:0]
- deq_funct3  out  3  deq_inst[14:12]
- deq_funct7  out  7  deq_inst[31:25]

Behaviour:
- Reset, synchronous, active-high, on clk rising edge:
  - state=REQ, fetch_pc=RESET_PC, FIFO empty (count=0, head=tail=0).
  - While rst=1, all outputs are 0, including inst_mem_read.
- First cycle after rst falls: inst_mem_read=1, inst_mem_address=RESET_PC.
- inst_mem_read is 1 exactly when state is REQ or DISCARD.
- inst_mem_address = fetch_pc, and is held stable while read=1 until resp.
- Only one request is ever outstanding.
- States:
  - IDLE: no request outstanding.
    - redirect: flush FIFO, fetch_pc<=redirect_pc&~3, go REQ.
    - else if count_next<DEPTH: go REQ.
  - REQ: request outstanding at fetch_pc.
    - resp without redirect: write {fetch_pc, rdata} to the FIFO tail and set fetch_pc<=fetch_pc+4, wrapping mod 2^32. Then stay REQ if count_next<DEPTH, else go IDLE.
    - resp with redirect on the same cycle: drop the data, flush, fetch_pc<=redirect_pc&~3, stay REQ.
    - redirect without resp: flush, latch target into fetch_pc_next, go DISCARD.
  - DISCARD: the old request is still in flight; address stays at the old PC.
    - resp: drop the data, fetch_pc<=fetch_pc_next, go REQ.
    - A further redirect while in DISCARD overwrites fetch_pc_next; the latest redirect wins.
- count_next = count + write - (deq_valid & deq_ready & ~redirect_valid).
- FIFO:
  - Circular buffer; pointers wrap mod DEPTH.
  - deq_valid = (count != 0) & ~rst.
  - deq_* outputs come from the head entry.
  - Pop on deq_valid & deq_ready.
  - Push and pop may occur in the same cycle at any count; count is then unchanged.
- Full: a push is never attempted when full. The request gating above guarantees space for the in-flight response.
- Redirect:
  - Flush takes precedence over pop and push in the same cycle.
  - deq_valid=0 in the cycle after a redirect.
- Latency (no bypass): resp in cycle N gives deq_valid=1 in cycle N+1.
- Back-to-back fetches: the address advances in the cycle after resp and read stays high.
- Reset asserted mid-request: return to the reset state. Any resp arriving during rst is ignored. The memory must tolerate an abandoned read.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- When defined, an empty-FIFO bypass applies when all of these hold: count==0, state==REQ, resp=1, redirect_valid=0.
  - deq_valid=1 in that cycle, with deq_inst=inst_mem_rdata and deq_pc=fetch_pc.
  - If deq_ready=1, the entry is consumed and not written to the FIFO.
  - If deq_ready=0, the entry is written normally.
- When undefined: no combinational path from inst_mem_* to deq_*. Minimum latency is 1 cycle after resp.

Test Plan:
- Reset release, memory responds 1 cycle after each request, deq_ready=1:
  - addresses 0x60, 0x64, 0x68 in sequence.
  - deq_pc/deq_inst match each address, one cycle after resp (same cycle with FETCH_BYPASS_EN).
- deq_ready=0, DEPTH=4:
  - exactly 4 responses accepted, then inst_mem_read=0 and count=4.
  - Raise deq_ready: 4 pops in order (0x60..0x6C), then fetching resumes at 0x70.
- redirect_valid=1, redirect_pc=0x203 while a request to 0x68 is pending, resp delayed 3 cycles:
  - address holds 0x68 until resp, and that data is dropped.
  - next address is 0x200; FIFO empty the cycle after redirect.
- Redirect and resp on the same cycle (target 0x400):
  - response not enqueued.
  - next cycle inst_mem_read=1, address 0x400.
- Simultaneous push and pop at count=2 for 10 cycles: count stays 2, PCs strictly +4.
- fetch_pc=0xFFFFFFFC fetch: next address wraps to 0x00000000.
- rst asserted mid-request: next cycle read=0; after release, address=0x60.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end with single-outstanding memory reads and a
// PC/instruction FIFO towards decode. Define FETCH_BYPASS_EN for the empty-FIFO bypass.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
    input  logic        clk,
    input  logic        rst,
    output logic        inst_mem_read,
    output logic [31:0] inst_mem_address,
    input  logic [31:0] inst_mem_rdata,
    input  logic        inst_mem_resp,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        deq_valid,
    input  logic        deq_ready,
    output logic [31:0] deq_pc,
    output logic [31:0] deq_inst,
    output logic [6:0]  deq_opcode,
    output logic [2:0]  deq_funct3,
    output logic [6:0]  deq_funct7
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DISCARD = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   target_pc_q, target_pc_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d, count_next;
    logic [31:0]   pc_mem_q   [DEPTH];
    logic [31:0]   inst_mem_q [DEPTH];

    logic [31:0]   redir_target;
    logic          fifo_valid;
    logic          push;
    logic          pop;
    logic          byp_take;

    assign redir_target = redirect_pc & 32'hFFFF_FFFC;
    assign fifo_valid   = (count_q != {CW{1'b0}});
    assign pop          = fifo_valid & deq_ready & ~redirect_valid;

`ifdef FETCH_BYPASS_EN
    logic byp_hit;
    assign byp_hit  = ~fifo_valid & (state_q == ST_REQ) & inst_mem_resp & ~redirect_valid;
    assign byp_take = byp_hit & deq_ready;
`else
    assign byp_take = 1'b0;
`endif

    // A response consumed by the bypass never occupies a FIFO slot.
    assign push       = (state_q == ST_REQ) & inst_mem_resp & ~redirect_valid & ~byp_take;
    assign count_next = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};

    // Next-state logic for the fetch FSM and FIFO pointers.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        target_pc_d = target_pc_q;
        case (state_q)
            ST_IDLE: begin
                if (redirect_valid) begin
                    fetch_pc_d = redir_target;
                    state_d    = ST_REQ;
                end else if (count_next < DEPTH_C) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (inst_mem_resp && redirect_valid) begin
                    fetch_pc_d = redir_target;
                    state_d    = ST_REQ;
                end else if (inst_mem_resp) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = (count_next < DEPTH_C) ? ST_REQ : ST_IDLE;
                end else if (redirect_valid) begin
                    target_pc_d = redir_target;
                    state_d     = ST_DISCARD;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_DISCARD: begin
                // Address stays on the abandoned PC until its response drains.
                if (inst_mem_resp) begin
                    fetch_pc_d = redirect_valid ? redir_target : target_pc_q;
                    state_d    = ST_REQ;
                end else if (redirect_valid) begin
                    target_pc_d = redir_target;
                    state_d     = ST_DISCARD;
                end else begin
                    state_d = ST_DISCARD;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase

        if (redirect_valid) begin
            head_d  = {PW{1'b0}};
            tail_d  = {PW{1'b0}};
            count_d = {CW{1'b0}};
        end else begin
            head_d  = pop  ? head_q + PW'(1) : head_q;
            tail_d  = push ? tail_q + PW'(1) : tail_q;
            count_d = count_next;
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_REQ;
            fetch_pc_q  <= RESET_PC;
            target_pc_q <= RESET_PC;
            head_q      <= {PW{1'b0}};
            tail_q      <= {PW{1'b0}};
            count_q     <= {CW{1'b0}};
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            target_pc_q <= target_pc_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
        end
    end

    // FIFO storage; contents are qualified by count so they need no reset.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            pc_mem_q[tail_q]   <= fetch_pc_q;
            inst_mem_q[tail_q] <= inst_mem_rdata;
        end
    end

    // Memory port drive, forced quiet while in reset.
    always_comb begin
        if (rst) begin
            inst_mem_read    = 1'b0;
            inst_mem_address = 32'h0000_0000;
        end else begin
            inst_mem_read    = (state_q == ST_REQ) || (state_q == ST_DISCARD);
            inst_mem_address = fetch_pc_q;
        end
    end

    // Decode-side head presentation.
    always_comb begin
        if (rst) begin
            deq_valid = 1'b0;
            deq_pc    = 32'h0000_0000;
            deq_inst  = 32'h0000_0000;
        end else if (fifo_valid) begin
            deq_valid = 1'b1;
            deq_pc    = pc_mem_q[head_q];
            deq_inst  = inst_mem_q[head_q];
`ifdef FETCH_BYPASS_EN
        end else if (byp_hit) begin
            deq_valid = 1'b1;
            deq_pc    = fetch_pc_q;
            deq_inst  = inst_mem_rdata;
`endif
        end else begin
            deq_valid = 1'b0;
            deq_pc    = 32'h0000_0000;
            deq_inst  = 32'h0000_0000;
        end
    end

    assign deq_opcode = deq_inst[6:0];
    assign deq_funct3 = deq_inst[14:12];
    assign deq_funct7 = deq_inst[31:25];

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: per-cycle vector table driving a latency-programmable
// memory model, with a scoreboard of expected {pc, inst} pairs checked at the decode port.
module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic        inst_mem_read;
    logic [31:0] inst_mem_address;
    logic [31:0] inst_mem_rdata;
    logic        inst_mem_resp;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        deq_valid;
    logic        deq_ready;
    logic [31:0] deq_pc;
    logic [31:0] deq_inst;
    logic [6:0]  deq_opcode;
    logic [2:0]  deq_funct3;
    logic [6:0]  deq_funct7;

    fetch_queue dut (
        .clk              (clk),
        .rst              (rst),
        .inst_mem_read    (inst_mem_read),
        .inst_mem_address (inst_mem_address),
        .inst_mem_rdata   (inst_mem_rdata),
        .inst_mem_resp    (inst_mem_resp),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .deq_valid        (deq_valid),
        .deq_ready        (deq_ready),
        .deq_pc           (deq_pc),
        .deq_inst         (deq_inst),
        .deq_opcode       (deq_opcode),
        .deq_funct3       (deq_funct3),
        .deq_funct7       (deq_funct7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        int          lat;
        logic        exp_read;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[$];
    ent_t sb[$];

    int n_tests;
    int n_fail;

    bit          pend;
    bit          stale;
    int          wait_c;
    logic [31:0] req_addr;

    function automatic logic [31:0] mk_inst(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_5A13;
    endfunction

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic v(input logic r, input logic rd, input logic [31:0] rpc, input logic rdy,
                     input int lat, input logic er, input logic [31:0] ea);
        vec_t t;
        t.rst = r; t.redir = rd; t.rpc = rpc; t.rdy = rdy;
        t.lat = lat; t.exp_read = er; t.exp_addr = ea;
        vecs.push_back(t);
    endtask

    task automatic cmp_head(input ent_t e);
        chk({deq_pc, deq_inst} == {e.pc, e.inst}, "deq_head", {deq_pc, deq_inst}, {e.pc, e.inst});
        chk({deq_opcode, deq_funct3, deq_funct7} == {e.inst[6:0], e.inst[14:12], e.inst[31:25]},
            "deq_fields", 64'({deq_opcode, deq_funct3, deq_funct7}),
            64'({e.inst[6:0], e.inst[14:12], e.inst[31:25]}));
    endtask

    // One clock cycle: entered and left at posedge+1.
    task automatic tick(input logic r, input logic rd, input logic [31:0] rpc, input logic rdy,
                        input int lat, input bit do_chk, input logic er, input logic [31:0] ea);
        bit   live;
        bit   byp;
        bit   exp_dv;
        ent_t e;
        rst            = r;
        redirect_valid = rd;
        redirect_pc    = rpc;
        deq_ready      = rdy;
        inst_mem_resp  = 1'b0;
        inst_mem_rdata = 32'h0000_0000;
        #1;
        if (do_chk) begin
            chk(inst_mem_read == er, "mem_read", 64'(inst_mem_read), 64'(er));
            chk(inst_mem_address == ea, "mem_addr", 64'(inst_mem_address), 64'(ea));
        end
        live = 1'b0;
        if (r) begin
            pend           = 1'b0;
            stale          = 1'b0;
            inst_mem_resp  = 1'b1;
            inst_mem_rdata = 32'hDEAD_BEEF;
        end else if (inst_mem_read) begin
            if (!pend) begin
                pend     = 1'b1;
                stale    = 1'b0;
                wait_c   = lat;
                req_addr = inst_mem_address;
            end else begin
                chk(inst_mem_address == req_addr, "addr_hold", 64'(inst_mem_address), 64'(req_addr));
            end
            if (wait_c == 0) begin
                inst_mem_resp  = 1'b1;
                inst_mem_rdata = mk_inst(req_addr);
                pend           = 1'b0;
                live           = !stale && !rd;
            end else begin
                wait_c--;
            end
        end
        if (rd && pend) stale = 1'b1;
        byp = 1'b0;
`ifdef FETCH_BYPASS_EN
        byp = (sb.size() == 0) && live;
`endif
        @(negedge clk);
        exp_dv = !r && ((sb.size() != 0) || byp);
        chk(deq_valid == exp_dv, "deq_valid", 64'(deq_valid), 64'(exp_dv));
        if (r) begin
            chk({deq_pc, deq_inst} == 64'h0, "rst_outs", {deq_pc, deq_inst}, 64'h0);
        end
        if (r || rd) begin
            sb.delete();
        end else begin
            if (sb.size() != 0) begin
                e = sb[0];
                cmp_head(e);
                if (rdy) void'(sb.pop_front());
            end else if (byp) begin
                e = {req_addr, mk_inst(req_addr)};
                cmp_head(e);
            end
            if (live && !(byp && rdy)) sb.push_back({req_addr, mk_inst(req_addr)});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        pend    = 1'b0;
        stale   = 1'b0;
        wait_c  = 0;
        req_addr = 32'h0;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; deq_ready = 1'b0;
        inst_mem_resp = 1'b0; inst_mem_rdata = 32'h0;

        // In-order fetch, then redirect to 0x203 while 0x68 is pending with a slow response.
        v(1'b1, 1'b0, 32'h0,   1'b1, 1, 1'b0, 32'h0);
        v(1'b0, 1'b0, 32'h0,   1'b1, 1, 1'b1, 32'h60);
        v(1'b0, 1'b0, 32'h0,   1'b1, 1, 1'b1, 32'h60);
        v(1'b0, 1'b0, 32'h0,   1'b1, 1, 1'b1, 32'h64);
        v(1'b0, 1'b0, 32'h0,   1'b1, 1, 1'b1, 32'h64);
        v(1'b0, 1'b0, 32'h0,   1'b1, 3, 1'b1, 32'h68);
        v(1'b0, 1'b1, 32'h203, 1'b1, 1, 1'b1, 32'h68);
        v(1'b0, 1'b0, 32'h0,   1'b1, 1, 1'b1, 32'h68);
        v(1'b0, 1'b0, 32'h0,   1'b1, 1, 1'b1, 32'h68);
        v(1'b0, 1'b0, 32'h0,   1'b1, 1, 1'b1, 32'h200);
        v(1'b0, 1'b0, 32'h0,   1'b1, 1, 1'b1, 32'h200);
        v(1'b0, 1'b0, 32'h0,   1'b1, 1, 1'b1, 32'h204);
        // Redirect coincident with response.
        v(1'b1, 1'b0, 32'h0,   1'b1, 1, 1'b0, 32'h0);
        v(1'b0, 1'b0, 32'h0,   1'b1, 1, 1'b1, 32'h60);
        v(1'b0, 1'b1, 32'h400, 1'b1, 1, 1'b1, 32'h60);
        v(1'b0, 1'b0, 32'h0,   1'b1, 1, 1'b1, 32'h400);
        v(1'b0, 1'b0, 32'h0,   1'b1, 1, 1'b1, 32'h400);
        v(1'b0, 1'b0, 32'h0,   1'b1, 1, 1'b1, 32'h404);
        // Fill to DEPTH with decode stalled, then drain and resume at 0x70.
        v(1'b1, 1'b0, 32'h0,   1'b0, 1, 1'b0, 32'h0);
        v(1'b0, 1'b0, 32'h0,   1'b0, 1, 1'b1, 32'h60);
        v(1'b0, 1'b0, 32'h0,   1'b0, 1, 1'b1, 32'h60);
        v(1'b0, 1'b0, 32'h0,   1'b0, 1, 1'b1, 32'h64);
        v(1'b0, 1'b0, 32'h0,   1'b0, 1, 1'b1, 32'h64);
        v(1'b0, 1'b0, 32'h0,   1'b0, 1, 1'b1, 32'h68);
        v(1'b0, 1'b0, 32'h0,   1'b0, 1, 1'b1, 32'h68);
        v(1'b0, 1'b0, 32'h0,   1'b0, 1, 1'b1, 32'h6C);
        v(1'b0, 1'b0, 32'h0,   1'b0, 1, 1'b1, 32'h6C);
        v(1'b0, 1'b0, 32'h0,   1'b0, 1, 1'b0, 32'h70);
        v(1'b0, 1'b0, 32'h0,   1'b0, 1, 1'b0, 32'h70);
        v(1'b0, 1'b0, 32'h0,   1'b1, 1, 1'b0, 32'h70);
        v(1'b0, 1'b0, 32'h0,   1'b1, 1, 1'b1, 32'h70);
        v(1'b0, 1'b0, 32'h0,   1'b1, 1, 1'b1, 32'h70);
        v(1'b0, 1'b0, 32'h0,   1'b1, 1, 1'b1, 32'h74);
        v(1'b0, 1'b0, 32'h0,   1'b1, 1, 1'b1, 32'h74);
        v(1'b0, 1'b0, 32'h0,   1'b1, 1, 1'b1, 32'h78);
        // PC wrap past 0xFFFFFFFC; low redirect bits ignored.
        v(1'b1, 1'b0, 32'h0,        1'b1, 1, 1'b0, 32'h0);
        v(1'b0, 1'b0, 32'h0,        1'b1, 1, 1'b1, 32'h60);
        v(1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 1, 1'b1, 32'h60);
        v(1'b0, 1'b0, 32'h0,        1'b1, 1, 1'b1, 32'hFFFFFFFC);
        v(1'b0, 1'b0, 32'h0,        1'b1, 1, 1'b1, 32'hFFFFFFFC);
        v(1'b0, 1'b0, 32'h0,        1'b1, 1, 1'b1, 32'h0);
        v(1'b0, 1'b0, 32'h0,        1'b1, 1, 1'b1, 32'h0);
        v(1'b0, 1'b0, 32'h0,        1'b1, 1, 1'b1, 32'h4);
        // Reset mid-request; responses during reset are ignored.
        v(1'b1, 1'b0, 32'h0,   1'b1, 1, 1'b0, 32'h0);
        v(1'b0, 1'b0, 32'h0,   1'b1, 3, 1'b1, 32'h60);
        v(1'b1, 1'b0, 32'h0,   1'b1, 1, 1'b0, 32'h0);
        v(1'b1, 1'b0, 32'h0,   1'b1, 1, 1'b0, 32'h0);
        v(1'b0, 1'b0, 32'h0,   1'b1, 1, 1'b1, 32'h60);
        v(1'b0, 1'b0, 32'h0,   1'b1, 1, 1'b1, 32'h60);
        v(1'b0, 1'b0, 32'h0,   1'b1, 1, 1'b1, 32'h64);
        // Two redirects while discarding: the later target wins.
        v(1'b1, 1'b0, 32'h0,   1'b1, 1, 1'b0, 32'h0);
        v(1'b0, 1'b0, 32'h0,   1'b1, 3, 1'b1, 32'h60);
        v(1'b0, 1'b1, 32'h500, 1'b1, 1, 1'b1, 32'h60);
        v(1'b0, 1'b1, 32'h600, 1'b1, 1, 1'b1, 32'h60);
        v(1'b0, 1'b0, 32'h0,   1'b1, 1, 1'b1, 32'h60);
        v(1'b0, 1'b0, 32'h0,   1'b1, 1, 1'b1, 32'h600);
        v(1'b0, 1'b0, 32'h0,   1'b1, 1, 1'b1, 32'h600);
        v(1'b0, 1'b0, 32'h0,   1'b1, 1, 1'b1, 32'h604);

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            tick(vecs[i].rst, vecs[i].redir, vecs[i].rpc, vecs[i].rdy, vecs[i].lat,
                 1'b1, vecs[i].exp_read, vecs[i].exp_addr);
        end

        // Zero-latency memory: hold two entries, then push and pop together for 10 cycles.
        tick(1'b1, 1'b0, 32'h0, 1'b0, 0, 1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 32'h0, 1'b0, 0, 1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 32'h0, 1'b0, 0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            chk(deq_valid && (deq_pc == inst_mem_address - 32'd8), "cnt2_pc",
                64'({deq_valid, deq_pc}), 64'({1'b1, inst_mem_address - 32'd8}));
            tick(1'b0, 1'b0, 32'h0, 1'b1, 0, 1'b0, 1'b0, 32'h0);
        end
        chk(deq_valid && (deq_pc == inst_mem_address - 32'd8), "cnt2_pc",
            64'({deq_valid, deq_pc}), 64'({1'b1, inst_mem_address - 32'd8}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
